// File: rtl/serial_link_pkg.sv
// serial_link_pkg
//   Shared definitions for the serial link (parallel2serial / serial2parallel).
//   - N_DEFAULT : default word width shared by both ends of the link
//   - ST_IDLE / ST_SHIFT and state_t : transmitter state encoding
//   - CNT_W(n) : bit-counter width for an n-bit frame
package serial_link_pkg;

  localparam int N_DEFAULT = 8;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } state_t;

  function automatic int CNT_W(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/p2s_hold_reg.sv
// p2s_hold_reg
//   One-entry valid/data register used as the skid buffer of parallel2serial.
//   A push and a pop in the same cycle leave the entry full with the new data.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-high reset, empties the entry
//   push   in   write din into the entry
//   pop    in   release the entry
//   din    in   W-bit word to park
//   valid  out  entry holds a word
//   data   out  parked word
module p2s_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (push) begin
      valid <= 1'b1;
      data  <= din;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/parallel2serial.sv
// parallel2serial
//   Serial link transmitter: accepts an N-bit word over valid/ready and shifts
//   it out LSB-first, one bit per clk, with serial_start on bit 0 and done on
//   bit N-1.
//   Build option P2S_SKID_EN: adds a one-entry hold buffer so that a word
//   accepted during a frame follows it with no idle gap. Without it the block
//   only accepts in IDLE and frames are separated by at least one idle cycle.
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-high reset
//   in_valid      in   producer offers a word on din
//   din           in   N-bit word, sampled only on accept
//   in_ready      out  a word can be accepted this cycle
//   q             out  serial data bit (registered, 0 when idle)
//   serial_start  out  pulse on bit 0 of each frame (registered)
//   busy          out  frame bits are on q this cycle
//   done          out  pulse on bit N-1 of each frame
module parallel2serial
  import serial_link_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [N-1:0] din,
  output logic         in_ready,
  output logic         q,
  output logic         serial_start,
  output logic         busy,
  output logic         done
);

  localparam int CW = CNT_W(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  state_t         state, state_n;
  logic [CW-1:0]  bit_cnt, bit_cnt_n;
  logic [N-1:0]   shift_reg, shift_reg_n;
  logic           start_r, start_n;

  logic           accept;
  logic           last;
  logic           hold_valid;
  logic [N-1:0]   hold_data;

  assign accept = in_valid && in_ready;
  assign last   = (state == SHIFT) && (bit_cnt == LAST_BIT);

`ifdef P2S_SKID_EN
  logic push;
  logic pop;

  // A word accepted on the last bit with the buffer empty loads the shift
  // register directly, so only mid-frame accepts are parked. Accept implies
  // an empty buffer, so drain and park never collide.
  assign push = accept && (state == SHIFT) && !last;
  assign pop  = last && hold_valid;

  p2s_hold_reg #(.W(N)) u_hold (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .valid (hold_valid),
    .data  (hold_data)
  );

  assign in_ready = !reset && !hold_valid;
`else
  assign hold_valid = 1'b0;
  assign hold_data  = '0;
  assign in_ready   = !reset && (state == IDLE);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      start_r   <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift_reg <= shift_reg_n;
      start_r   <= start_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_reg_n = shift_reg;
    start_n     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n     = SHIFT;
          bit_cnt_n   = '0;
          shift_reg_n = din;
          start_n     = 1'b1;
        end
      end
      SHIFT: begin
        if (!last) begin
          bit_cnt_n   = bit_cnt + CW'(1);
          shift_reg_n = {1'b0, shift_reg[N-1:1]};
        end else if (hold_valid) begin
          // Parked word goes first; it was accepted before anything newer.
          bit_cnt_n   = '0;
          shift_reg_n = hold_data;
          start_n     = 1'b1;
        end else if (accept) begin
          bit_cnt_n   = '0;
          shift_reg_n = din;
          start_n     = 1'b1;
        end else begin
          state_n     = IDLE;
          bit_cnt_n   = '0;
          shift_reg_n = '0;
        end
      end
      default: begin
        state_n     = IDLE;
        bit_cnt_n   = '0;
        shift_reg_n = '0;
      end
    endcase
  end

  // shift_reg is zero in IDLE, so q reads 0 between frames.
  assign q            = shift_reg[0];
  assign serial_start = start_r;
  assign busy         = (state == SHIFT);
  assign done         = last;

endmodule
